frame_delimiter_detector: RTL and testbench

Byte-level framing stage that sits directly upstream of the communication selector. It watches the UART receive byte stream, recognises start/end-of-frame delimiters with escape handling, and produces the one-cycle `communication_initiated` / `communication_ended` pulses the selector consumes. It also forwards de-escaped payload bytes and flags aborted frames caused by overlength, line errors, timeout or a restart.

---
 rtl/frame_delimiter_detector_pkg.sv | 19 +
 rtl/frame_delimiter_detector_idle_timeout_counter.sv | 31 +++
 rtl/frame_delimiter_detector.sv | 131 +++++++++++++
 tb/tb_frame_delimiter_detector.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_delimiter_detector_pkg.sv
// Shared framing definitions: FSM state encoding and the delimiter bytes, also used by the
// transmit-side framer so both ends agree on the wire format.
package frame_delimiter_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_FRAME,
        ST_ESCAPED,
        ST_RESTART
    } fdd_state_t;

    localparam logic [7:0] SOF_BYTE = 8'h02;
    localparam logic [7:0] EOF_BYTE = 8'h03;
    localparam logic [7:0] ESC_BYTE = 8'h1B;

    localparam int DEFAULT_MAX_LEN        = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/frame_delimiter_detector_idle_timeout_counter.sv
// Idle watchdog for an open frame: counts enabled cycles since the last clear and flags
// expiry combinationally so the parent can register it alongside its other outputs.
module idle_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at LAST_CNT instead of wrapping; the parent leaves the frame on expiry anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST_CNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count == LAST_CNT);

endmodule

// File: rtl/frame_delimiter_detector.sv
// Receive-side framing FSM: turns the UART byte stream into frame start/end pulses,
// de-escaped payload strobes and abort indications.
module frame_delimiter_detector
    import frame_delimiter_detector_pkg::*;
#(
    parameter int MAX_LEN        = DEFAULT_MAX_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic       communication_initiated,
    output logic       communication_ended,
    output logic       frame_aborted,
    output logic       payload_valid,
    output logic [7:0] payload_data
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    fdd_state_t       r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_init;
    logic             r_ended;
    logic             r_aborted;
    logic             r_pvalid;
    logic [7:0]       r_pdata;

    logic             w_restart;
    logic             w_tmo_enable;
    logic             w_tmo_clear;
    logic             w_expired;
    logic             w_is_delim;
    logic             w_is_payload;
    logic [LEN_W-1:0] w_len_eff;

    assign w_restart    = (r_state == ST_RESTART);
    assign w_tmo_enable = (r_state == ST_IN_FRAME) || (r_state == ST_ESCAPED);
    assign w_tmo_clear  = rx_valid || w_restart;
    assign w_is_delim   = (rx_data == SOF_BYTE) || (rx_data == EOF_BYTE) || (rx_data == ESC_BYTE);
    assign w_is_payload = (r_state == ST_ESCAPED) || !w_is_delim;
    assign w_len_eff    = w_restart ? '0 : r_len;

    idle_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (w_tmo_enable),
        .i_clear  (w_tmo_clear),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_init    <= 1'b0;
            r_ended   <= 1'b0;
            r_aborted <= 1'b0;
            r_pvalid  <= 1'b0;
            r_pdata   <= 8'h00;
        end else begin
            r_init    <= 1'b0;
            r_ended   <= 1'b0;
            r_aborted <= 1'b0;
            r_pvalid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && !rx_error && (rx_data == SOF_BYTE)) begin
                        r_state <= ST_IN_FRAME;
                        r_len   <= '0;
                        r_init  <= 1'b1;
                    end
                end
                default: begin
                    if (w_restart) begin
                        r_state <= ST_IN_FRAME;
                        r_len   <= '0;
                        r_init  <= 1'b1;
                    end
                    // In the restart cycle only payload/escape bytes are taken; anything that
                    // would close the frame is dropped so initiated and ended never coincide.
                    if (rx_error && !w_restart) begin
                        r_state   <= ST_IDLE;
                        r_ended   <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (w_expired) begin
                        r_state   <= ST_IDLE;
                        r_ended   <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (rx_valid && !rx_error) begin
                        if (w_is_payload) begin
                            if (w_len_eff < MAX_LEN_V) begin
                                r_state  <= ST_IN_FRAME;
                                r_pvalid <= 1'b1;
                                r_pdata  <= rx_data;
                                r_len    <= w_len_eff + 1'b1;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_ended   <= 1'b1;
                                r_aborted <= 1'b1;
                            end
                        end else if (rx_data == ESC_BYTE) begin
                            r_state <= ST_ESCAPED;
                        end else if (!w_restart) begin
                            if (rx_data == EOF_BYTE) begin
                                r_state <= ST_IDLE;
                                r_ended <= 1'b1;
                            end else begin
                                r_state   <= ST_RESTART;
                                r_ended   <= 1'b1;
                                r_aborted <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign communication_initiated = r_init;
    assign communication_ended     = r_ended;
    assign frame_aborted           = r_aborted;
    assign payload_valid           = r_pvalid;
    assign payload_data            = r_pdata;

endmodule

// File: tb/tb_frame_delimiter_detector.sv
// Bench for frame_delimiter_detector: directed scenarios plus randomized streams scored
// against a frame-level reference model.
module tb_frame_delimiter_detector;

    localparam logic [7:0] SOF  = 8'h02;
    localparam logic [7:0] EOF  = 8'h03;
    localparam logic [7:0] ESC  = 8'h1B;
    localparam int         MAXL = 4;
    localparam int         TMO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       communication_initiated;
    logic       communication_ended;
    logic       frame_aborted;
    logic       payload_valid;
    logic [7:0] payload_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] fl;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] d;
    } stim_t;

    ev_t   cap_q[$];
    ev_t   exp_q[$];
    stim_t stim_q[$];
    int    cyc = 0;
    bit    capture_en = 1'b0;

    always #5 clk = ~clk;

    frame_delimiter_detector #(
        .MAX_LEN(MAXL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .rx_valid               (rx_valid),
        .rx_data                (rx_data),
        .rx_error               (rx_error),
        .communication_initiated(communication_initiated),
        .communication_ended    (communication_ended),
        .frame_aborted          (frame_aborted),
        .payload_valid          (payload_valid),
        .payload_data           (payload_data)
    );

    // {initiated, ended, aborted, payload_valid}
    function automatic logic [3:0] flags();
        return {communication_initiated, communication_ended, frame_aborted, payload_valid};
    endfunction

    task automatic step(input logic v, input logic e, input logic [7:0] d);
        ev_t ev;
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        if (capture_en && (flags() != 4'b0000)) begin
            ev.cyc  = cyc;
            ev.fl   = flags();
            ev.data = payload_valid ? payload_data : 8'h00;
            cap_q.push_back(ev);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (flags() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", flags());
        end
        checks++;
        if (payload_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_payload_data got=%h exp=00", payload_data);
        end
    endtask

    task automatic test_normal();
        logic [7:0] b[4];
        logic [3:0] ef[4];
        b  = '{SOF, 8'h41, 8'h42, EOF};
        ef = '{4'b1000, 4'b0001, 4'b0001, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, b[i]);
            checks++;
            if (flags() !== ef[i] || (ef[i][0] && payload_data !== b[i])) begin
                failures++;
                $display("FAIL normal[%0d] flags=%b data=%h exp flags=%b data=%h", i, flags(), payload_data, ef[i], b[i]);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (flags() !== 4'b0000 || payload_data !== 8'h42) begin
            failures++;
            $display("FAIL normal_hold flags=%b data=%h exp flags=0000 data=42", flags(), payload_data);
        end
    endtask

    task automatic test_escape();
        logic [7:0] b[6];
        logic [3:0] ef[6];
        logic [7:0] ed[6];
        b  = '{SOF, ESC, EOF, ESC, ESC, EOF};
        ef = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0100};
        ed = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h1B, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, b[i]);
            checks++;
            if (flags() !== ef[i] || (ef[i][0] && payload_data !== ed[i])) begin
                failures++;
                $display("FAIL escape[%0d] flags=%b data=%h exp flags=%b data=%h", i, flags(), payload_data, ef[i], ed[i]);
            end
        end
    endtask

    task automatic test_overlength();
        logic [7:0] b[7];
        logic [3:0] ef[7];
        b  = '{SOF, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        ef = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0110, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, b[i]);
            checks++;
            if (flags() !== ef[i] || (ef[i][0] && payload_data !== b[i])) begin
                failures++;
                $display("FAIL overlength[%0d] flags=%b data=%h exp flags=%b data=%h", i, flags(), payload_data, ef[i], b[i]);
            end
        end
    endtask

    task automatic test_restart_error();
        logic [7:0] b[5];
        logic [3:0] ef[5];
        logic [7:0] ed[5];
        b  = '{SOF, 8'h41, SOF, 8'h42, EOF};
        ef = '{4'b1000, 4'b0001, 4'b0110, 4'b1001, 4'b0100};
        ed = '{8'h00, 8'h41, 8'h00, 8'h42, 8'h00};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, b[i]);
            checks++;
            if (flags() !== ef[i] || (ef[i][0] && payload_data !== ed[i])) begin
                failures++;
                $display("FAIL restart[%0d] flags=%b data=%h exp flags=%b data=%h", i, flags(), payload_data, ef[i], ed[i]);
            end
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (flags() !== 4'b0000) begin
            failures++;
            $display("FAIL error_idle_ignored flags=%b exp=0000", flags());
        end
        step(1'b1, 1'b0, SOF);
        step(1'b1, 1'b0, 8'h41);
        step(1'b1, 1'b1, 8'h43);
        checks++;
        if (flags() !== 4'b0110) begin
            failures++;
            $display("FAIL error_abort flags=%b exp=0110", flags());
        end
        step(1'b1, 1'b0, 8'h44);
        checks++;
        if (flags() !== 4'b0000) begin
            failures++;
            $display("FAIL error_then_idle flags=%b exp=0000", flags());
        end
    endtask

    task automatic test_timeout();
        int n;
        int bad;
        bit got;
        step(1'b1, 1'b0, SOF);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
            if (communication_ended) got = 1'b1;
        end
        checks++;
        if (!got || n != TMO || frame_aborted !== 1'b1) begin
            failures++;
            $display("FAIL timeout_silence got=%0d cycles=%0d aborted=%b exp cycles=%0d aborted=1", got, n, frame_aborted, TMO);
        end
        step(1'b1, 1'b0, SOF);
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            repeat ((j == 4) ? TMO - 1 : TMO - 2) begin
                step(1'b0, 1'b0, 8'h00);
                if (flags() !== 4'b0000) bad++;
            end
            if (j < 4) begin
                step(1'b1, 1'b0, 8'(8'h41 + j));
                checks++;
                if (flags() !== 4'b0001 || payload_data !== 8'(8'h41 + j)) begin
                    failures++;
                    $display("FAIL periodic_byte[%0d] flags=%b data=%h exp flags=0001", j, flags(), payload_data);
                end
            end else begin
                step(1'b1, 1'b0, EOF);
                checks++;
                if (flags() !== 4'b0100) begin
                    failures++;
                    $display("FAIL periodic_eof flags=%b exp=0100", flags());
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL periodic_quiet spurious_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b[6];
        logic [3:0] ef[6];
        int bad;
        step(1'b1, 1'b0, SOF);
        step(1'b1, 1'b0, 8'h41);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flags() !== 4'b0000 || payload_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset flags=%b data=%h exp flags=0000 data=00", flags(), payload_data);
        end
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (flags() !== 4'b0000) bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_no_end_pulse pulses=%0d exp=0", bad);
        end
        b  = '{SOF, 8'h51, 8'h52, 8'h53, 8'h54, EOF};
        ef = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, b[i]);
            checks++;
            if (flags() !== ef[i]) begin
                failures++;
                $display("FAIL post_reset[%0d] flags=%b exp=%b", i, flags(), ef[i]);
            end
        end
    endtask

    function automatic void push_exp(input int c, input logic [3:0] fl, input logic [7:0] d);
        ev_t ev;
        ev.cyc  = c;
        ev.fl   = fl;
        ev.data = d;
        exp_q.push_back(ev);
    endfunction

    // Frame-level reference: walks the byte/error events and applies the framing rules.
    function automatic void model();
        bit         inf = 1'b0;
        bit         esc = 1'b0;
        int         len = 0;
        int         lc = 0;
        logic [7:0] d;
        exp_q.delete();
        for (int e = 0; e < stim_q.size(); e++) begin
            if (!stim_q[e].v && !stim_q[e].e) continue;
            if (inf && e > lc + TMO) begin
                push_exp(lc + TMO, 4'b0110, 8'h00);
                inf = 1'b0;
            end
            if (stim_q[e].e) begin
                if (inf) begin
                    push_exp(e, 4'b0110, 8'h00);
                    inf = 1'b0;
                end
                continue;
            end
            d = stim_q[e].d;
            if (!inf) begin
                if (d == SOF) begin
                    push_exp(e, 4'b1000, 8'h00);
                    inf = 1'b1;
                    esc = 1'b0;
                    len = 0;
                    lc  = e;
                end
                continue;
            end
            lc = e;
            if (esc || !(d == SOF || d == EOF || d == ESC)) begin
                esc = 1'b0;
                if (len < MAXL) begin
                    push_exp(e, 4'b0001, d);
                    len++;
                end else begin
                    push_exp(e, 4'b0110, 8'h00);
                    inf = 1'b0;
                end
            end else if (d == ESC) begin
                esc = 1'b1;
            end else if (d == EOF) begin
                push_exp(e, 4'b0100, 8'h00);
                inf = 1'b0;
            end else begin
                push_exp(e, 4'b0110, 8'h00);
                push_exp(e + 1, 4'b1000, 8'h00);
                len = 0;
                lc  = e + 1;
            end
        end
        if (inf && stim_q.size() > lc + TMO) push_exp(lc + TMO, 4'b0110, 8'h00);
    endfunction

    task automatic test_random(input int round);
        stim_t s;
        int    r;
        int    gap;
        int    n;
        do_reset();
        stim_q.delete();
        while (stim_q.size() < 500) begin
            gap = ($urandom_range(0, 99) < 6) ? $urandom_range(TMO + 1, TMO + 4) : $urandom_range(1, 3);
            repeat (gap) begin
                s = '{1'b0, 1'b0, 8'h00};
                stim_q.push_back(s);
            end
            r = $urandom_range(0, 99);
            s.e = (r < 4);
            s.v = s.e ? 1'($urandom_range(0, 1)) : 1'b1;
            r = $urandom_range(0, 99);
            s.d = (r < 14) ? SOF : (r < 26) ? EOF : (r < 36) ? ESC : 8'($urandom_range(0, 255));
            stim_q.push_back(s);
        end
        repeat (TMO + 14) begin
            s = '{1'b0, 1'b0, 8'h00};
            stim_q.push_back(s);
        end
        model();
        cap_q.delete();
        cyc = 0;
        capture_en = 1'b1;
        foreach (stim_q[i]) step(stim_q[i].v, stim_q[i].e, stim_q[i].d);
        capture_en = 1'b0;
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rnd%0d_event_count got=%0d exp=%0d", round, cap_q.size(), exp_q.size());
        end
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_q[i].cyc != exp_q[i].cyc || cap_q[i].fl !== exp_q[i].fl || cap_q[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL rnd%0d_ev[%0d] cyc=%0d flags=%b data=%h exp cyc=%0d flags=%b data=%h", round, i,
                         cap_q[i].cyc, cap_q[i].fl, cap_q[i].data, exp_q[i].cyc, exp_q[i].fl, exp_q[i].data);
            end
        end
        $display("random round %0d: %0d stimulus cycles, %0d expected events, %0d observed", round,
                 stim_q.size(), exp_q.size(), cap_q.size());
    endtask

    initial begin
        test_reset();
        test_normal();
        test_escape();
        test_overlength();
        test_restart_error();
        test_timeout();
        test_reset_mid_frame();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
